// File: rtl/seqdet_sched.sv
// seqdet_sched: round-robin scheduler that time-shares one bit-serial Moore
// sequence detector among four parallel-word requesters and counts its matches.
module seqdet_sched #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic [3:0]       ack,
  output logic             det_rst_n,
  output logic             det_x,
  input  logic             det_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_ch,
  output logic [CW-1:0]    res_cnt,
  output logic             res_hit,
  output logic             busy
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Returns {found, channel}; search begins one past the last granted channel.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      c = last + 2'(i);
      if (!res[2] && r[c]) begin
        res = {1'b1, c};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] sel_word(input logic [1:0] ch,
                                                input logic [WIDTH-1:0] d0,
                                                input logic [WIDTH-1:0] d1,
                                                input logic [WIDTH-1:0] d2,
                                                input logic [WIDTH-1:0] d3);
    logic [WIDTH-1:0] w;
    case (ch)
      2'd0:    w = d0;
      2'd1:    w = d1;
      2'd2:    w = d2;
      2'd3:    w = d3;
      default: w = {WIDTH{1'b0}};
    endcase
    return w;
  endfunction

  state_t           state_r, state_s;
  logic [1:0]       last_r;
  logic [WIDTH-1:0] sh_r;
  logic [IW-1:0]    idx_r;
  logic [CW-1:0]    cnt_r;
  logic [3:0]       ack_r;
  logic             det_rst_n_r, det_x_r, res_valid_r, res_hit_r, busy_r;
  logic [1:0]       res_ch_r;
  logic [CW-1:0]    res_cnt_r;

  logic [2:0]       pick_s;
  logic             grant_s, sample_s;
  logic [CW-1:0]    cnt_nx_s;
  logic [WIDTH-1:0] word_s;

  // Next-state, grant decision and saturating match-count update.
  always_comb begin
    state_s  = state_r;
    pick_s   = rr_pick(req, last_r);
    grant_s  = 1'b0;
    word_s   = sel_word(pick_s[1:0], data0, data1, data2, data3);
    // SHIFT index 0 still sees the cleared detector, so it is not sampled.
    sample_s = ((state_r == S_SHIFT) && (idx_r != {IW{1'b0}})) || (state_r == S_DRAIN);
    if (sample_s && det_z && (cnt_r != CNT_MAX)) begin
      cnt_nx_s = cnt_r + CW'(1);
    end else begin
      cnt_nx_s = cnt_r;
    end
    case (state_r)
      S_IDLE: begin
        if (pick_s[2]) begin
          state_s = S_CLR;
          grant_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLR:   state_s = S_SHIFT;
      S_SHIFT: begin
        if (idx_r == LAST_IDX) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_SHIFT;
        end
      end
      S_DRAIN: state_s = S_DONE;
      S_DONE: begin
        if (res_valid_r && res_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs, all derived from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r      <= 2'd3;
      sh_r        <= {WIDTH{1'b0}};
      idx_r       <= {IW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      ack_r       <= 4'b0000;
      det_rst_n_r <= 1'b0;
      det_x_r     <= 1'b0;
      res_valid_r <= 1'b0;
      res_ch_r    <= 2'd0;
      res_cnt_r   <= {CW{1'b0}};
      res_hit_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      ack_r       <= grant_s ? (4'b0001 << pick_s[1:0]) : 4'b0000;
      det_rst_n_r <= (state_s != S_CLR);
      det_x_r     <= (state_s == S_SHIFT) ? sh_r[WIDTH-1] : 1'b0;
      busy_r      <= (state_s != S_IDLE);
      res_valid_r <= (state_s == S_DONE);
      if (grant_s) begin
        last_r   <= pick_s[1:0];
        res_ch_r <= pick_s[1:0];
        sh_r     <= word_s;
        idx_r    <= {IW{1'b0}};
        cnt_r    <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_nx_s;
        if (state_s == S_SHIFT) begin
          sh_r <= {sh_r[WIDTH-2:0], 1'b0};
        end
        if (state_r == S_SHIFT) begin
          idx_r <= idx_r + IW'(1);
        end
      end
      // The DRAIN sample is the last one, so the result is frozen here.
      if (state_r == S_DRAIN) begin
        res_cnt_r <= cnt_nx_s;
        res_hit_r <= (cnt_nx_s != {CW{1'b0}});
      end
    end
  end

  assign ack       = ack_r;
  assign det_rst_n = det_rst_n_r;
  assign det_x     = det_x_r;
  assign res_valid = res_valid_r;
  assign res_ch    = res_ch_r;
  assign res_cnt   = res_cnt_r;
  assign res_hit   = res_hit_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_seqdet_sched.sv
// tb_seqdet_sched: scenario tasks plus randomized traffic for seqdet_sched,
// with a behavioural 10010 detector and a word-level match/arbitration model.
module tb_seqdet_sched;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req = 4'd0;
  logic [WIDTH-1:0] wd [4];
  logic [WIDTH-1:0] data0, data1, data2, data3;
  logic res_ready = 1'b0;
  logic det_z;
  logic [3:0] ack;
  logic det_rst_n, det_x, res_valid, res_hit, busy;
  logic [1:0] res_ch;
  logic [CW-1:0] res_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  assign data0 = wd[0];
  assign data1 = wd[1];
  assign data2 = wd[2];
  assign data3 = wd[3];

  seqdet_sched #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .ack(ack), .det_rst_n(det_rst_n), .det_x(det_x), .det_z(det_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_cnt(res_cnt), .res_hit(res_hit), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Moore detector for 10010 with overlap: output is a function of the bit history.
  logic [4:0] hist = 5'd0;
  int nb = 0;
  always @(posedge clk) begin
    if (!det_rst_n) begin
      hist <= 5'd0;
      nb   <= 0;
    end else begin
      hist <= {hist[3:0], det_x};
      nb   <= (nb < 5) ? nb + 1 : 5;
    end
  end
  assign det_z = (nb >= 5) && (hist == 5'b10010);

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int model_cnt(input logic [WIDTH-1:0] d);
    int c;
    logic [WIDTH-1:0] t;
    c = 0;
    for (int i = 0; i + 5 <= WIDTH; i++) begin
      t = d >> (WIDTH - 5 - i);
      if (t[4:0] == 5'b10010) c++;
    end
    if (c > 2 ** CW - 1) c = 2 ** CW - 1;
    return c;
  endfunction

  function automatic int rr_next(input int last, input logic [3:0] r);
    for (int i = 1; i <= 4; i++) if (r[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction

  function automatic logic [14:0] outs_vec();
    return {ack, det_rst_n, det_x, res_valid, res_ch, res_cnt, res_hit, busy};
  endfunction

  // Follows one word from its ack to its first res_valid cycle (bounded waits).
  task automatic observe(input bit keep, output logic [3:0] a, output int t_ack,
                         output logic [WIDTH-1:0] xs, output logic rn_clr, output logic rn_sh,
                         output logic x_drain, output int t_val, output logic [1:0] ch,
                         output logic [CW-1:0] cnt, output logic hit, output bit ok);
    int lim;
    ok = 1'b1; a = 4'd0; t_ack = 0; xs = '0; rn_clr = 1'b1; rn_sh = 1'b1;
    x_drain = 1'b0; t_val = 0; ch = 2'd0; cnt = '0; hit = 1'b0;
    lim = 0;
    while (ack === 4'd0 && lim < 200) begin @(negedge clk); lim++; end
    if (lim >= 200) begin ok = 1'b0; return; end
    a = ack; t_ack = cyc; rn_clr = det_rst_n;
    if (!keep) req = req & ~ack;
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      xs[WIDTH-1-k] = det_x;
      rn_sh = rn_sh & det_rst_n;
    end
    @(negedge clk);
    x_drain = det_x;
    lim = 0;
    while (res_valid !== 1'b1 && lim < 200) begin @(negedge clk); lim++; end
    if (lim >= 200) begin ok = 1'b0; return; end
    t_val = cyc; ch = res_ch; cnt = res_cnt; hit = res_hit;
  endtask

  logic [3:0] o_a; int o_tack, o_tval; logic [WIDTH-1:0] o_xs;
  logic o_rnc, o_rns, o_xd, o_hit; logic [1:0] o_ch; logic [CW-1:0] o_cnt; bit o_ok;

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (outs_vec() !== 15'd0) begin n_err++; $display("FAIL reset_outs got=%h exp=0", outs_vec()); end
    repeat (2) @(negedge clk);
    n_cmp++; if (outs_vec() !== 15'd0) begin n_err++; $display("FAIL reset_hold got=%h exp=0", outs_vec()); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (det_rst_n !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL reset_release det_rst_n=%b busy=%b exp 1/0", det_rst_n, busy); end
  endtask

  task automatic test_round_robin();
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int prev = 0;
    wd[0] = 8'h92; wd[1] = 8'h12; wd[2] = 8'hFF; wd[3] = 8'h49;
    res_ready = 1'b1; req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      observe(1'b1, o_a, o_tack, o_xs, o_rnc, o_rns, o_xd, o_tval, o_ch, o_cnt, o_hit, o_ok);
      n_cmp++; if (!o_ok || o_ch !== 2'(exp_ord[i]) || o_a !== (4'b0001 << exp_ord[i]))
        begin n_err++; $display("FAIL rr_order[%0d] ch=%0d ack=%b ok=%0d exp ch=%0d", i, o_ch, o_a, o_ok, exp_ord[i]); end
      n_cmp++; if (o_cnt !== CW'(model_cnt(wd[exp_ord[i]])))
        begin n_err++; $display("FAIL rr_cnt[%0d] got=%0d exp=%0d", i, o_cnt, model_cnt(wd[exp_ord[i]])); end
      if (i > 0) begin
        n_cmp++; if (o_tack - prev !== WIDTH + 4)
          begin n_err++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", i, o_tack - prev, WIDTH + 4); end
      end
      prev = o_tack;
    end
    req = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int t_req;
    wd[0] = 8'b10010010; res_ready = 1'b1; req = 4'b0001; t_req = cyc;
    observe(1'b0, o_a, o_tack, o_xs, o_rnc, o_rns, o_xd, o_tval, o_ch, o_cnt, o_hit, o_ok);
    n_cmp++; if (!o_ok || o_a !== 4'b0001 || o_tack - t_req !== 1)
      begin n_err++; $display("FAIL single_ack ack=%b at=%0d ok=%0d exp 0001 at 1", o_a, o_tack - t_req, o_ok); end
    n_cmp++; if (o_xs !== 8'b10010010 || o_xd !== 1'b0)
      begin n_err++; $display("FAIL single_detx got=%b drain=%b exp=10010010/0", o_xs, o_xd); end
    n_cmp++; if (o_tval - t_req !== WIDTH + 3)
      begin n_err++; $display("FAIL single_valid_cycle got=%0d exp=%0d", o_tval - t_req, WIDTH + 3); end
    n_cmp++; if (o_ch !== 2'd0 || o_cnt !== 4'd2 || o_hit !== 1'b1 || busy !== 1'b1)
      begin n_err++; $display("FAIL single_result ch=%0d cnt=%0d hit=%b busy=%b exp 0/2/1/1", o_ch, o_cnt, o_hit, busy); end
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL single_valid_pulse valid=%b busy=%b exp 0/0", res_valid, busy); end
  endtask

  task automatic test_nomatch();
    n_cmp++; if (det_rst_n !== 1'b1) begin n_err++; $display("FAIL nomatch_idle_rstn got=%b exp=1", det_rst_n); end
    wd[2] = 8'hFF; res_ready = 1'b1; req = 4'b0100;
    observe(1'b0, o_a, o_tack, o_xs, o_rnc, o_rns, o_xd, o_tval, o_ch, o_cnt, o_hit, o_ok);
    n_cmp++; if (!o_ok || o_ch !== 2'd2 || o_cnt !== 4'd0 || o_hit !== 1'b0)
      begin n_err++; $display("FAIL nomatch_result ch=%0d cnt=%0d hit=%b ok=%0d exp 2/0/0", o_ch, o_cnt, o_hit, o_ok); end
    n_cmp++; if (o_rnc !== 1'b0 || o_rns !== 1'b1)
      begin n_err++; $display("FAIL nomatch_detrst clr=%b shift=%b exp 0/1", o_rnc, o_rns); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [1:0] c0; logic [CW-1:0] k0; logic h0; int t_acc;
    wd[2] = 8'h49; res_ready = 1'b0; req = 4'b0100;
    observe(1'b0, o_a, o_tack, o_xs, o_rnc, o_rns, o_xd, o_tval, o_ch, o_cnt, o_hit, o_ok);
    c0 = o_ch; k0 = o_cnt; h0 = o_hit;
    n_cmp++; if (!o_ok || c0 !== 2'd2 || k0 !== CW'(model_cnt(8'h49)) || h0 !== 1'b1)
      begin n_err++; $display("FAIL bp_result ch=%0d cnt=%0d hit=%b exp 2/%0d/1", c0, k0, h0, model_cnt(8'h49)); end
    wd[3] = 8'h92; req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (res_valid !== 1'b1 || res_ch !== c0 || res_cnt !== k0 || res_hit !== h0 || ack !== 4'd0)
        begin n_err++; $display("FAIL bp_hold[%0d] valid=%b ch=%0d cnt=%0d hit=%b ack=%b", i, res_valid, res_ch, res_cnt, res_hit, ack); end
    end
    res_ready = 1'b1; t_acc = cyc;
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0 || ack !== 4'd0)
      begin n_err++; $display("FAIL bp_accept valid=%b ack=%b exp 0/0000", res_valid, ack); end
    observe(1'b0, o_a, o_tack, o_xs, o_rnc, o_rns, o_xd, o_tval, o_ch, o_cnt, o_hit, o_ok);
    n_cmp++; if (!o_ok || o_a !== 4'b1000 || o_tack - t_acc !== 2 || o_cnt !== 4'd2)
      begin n_err++; $display("FAIL bp_next ack=%b dt=%0d cnt=%0d exp 1000/2/2", o_a, o_tack - t_acc, o_cnt); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lim = 0;
    wd[0] = 8'h92; wd[2] = 8'h12; res_ready = 1'b1; req = 4'b0001;
    while (ack === 4'd0 && lim < 200) begin @(negedge clk); lim++; end
    n_cmp++; if (lim >= 200) begin n_err++; $display("FAIL rmid_ack timeout exp ack"); end
    req = 4'd0;
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy got=%b exp=1", busy); end
    rst = 1'b0;
    #1;
    n_cmp++; if (outs_vec() !== 15'd0) begin n_err++; $display("FAIL rmid_async got=%h exp=0", outs_vec()); end
    @(negedge clk);
    n_cmp++; if (outs_vec() !== 15'd0) begin n_err++; $display("FAIL rmid_hold got=%h exp=0", outs_vec()); end
    @(negedge clk);
    rst = 1'b1; req = 4'b0101;
    observe(1'b0, o_a, o_tack, o_xs, o_rnc, o_rns, o_xd, o_tval, o_ch, o_cnt, o_hit, o_ok);
    n_cmp++; if (!o_ok || o_ch !== 2'd0 || o_cnt !== 4'd2 || o_hit !== 1'b1)
      begin n_err++; $display("FAIL rmid_first ch=%0d cnt=%0d hit=%b exp 0/2/1", o_ch, o_cnt, o_hit); end
    observe(1'b0, o_a, o_tack, o_xs, o_rnc, o_rns, o_xd, o_tval, o_ch, o_cnt, o_hit, o_ok);
    n_cmp++; if (!o_ok || o_ch !== 2'd2 || o_cnt !== CW'(model_cnt(8'h12)))
      begin n_err++; $display("FAIL rmid_second ch=%0d cnt=%0d exp 2/%0d", o_ch, o_cnt, model_cnt(8'h12)); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int prev;
    wd[1] = 8'b00000100; res_ready = 1'b1; req = 4'b0010;
    observe(1'b1, o_a, o_tack, o_xs, o_rnc, o_rns, o_xd, o_tval, o_ch, o_cnt, o_hit, o_ok);
    n_cmp++; if (!o_ok || o_ch !== 2'd1 || o_cnt !== 4'd0)
      begin n_err++; $display("FAIL b2b_first ch=%0d cnt=%0d exp 1/0", o_ch, o_cnt); end
    prev = o_tack; wd[1] = 8'b10000000;
    observe(1'b1, o_a, o_tack, o_xs, o_rnc, o_rns, o_xd, o_tval, o_ch, o_cnt, o_hit, o_ok);
    n_cmp++; if (!o_ok || o_ch !== 2'd1 || o_cnt !== 4'd0 || o_hit !== 1'b0 || o_xs !== 8'b10000000)
      begin n_err++; $display("FAIL b2b_second ch=%0d cnt=%0d hit=%b xs=%b exp 1/0/0/10000000", o_ch, o_cnt, o_hit, o_xs); end
    n_cmp++; if (o_tack - prev !== WIDTH + 4)
      begin n_err++; $display("FAIL b2b_spacing got=%0d exp=%0d", o_tack - prev, WIDTH + 4); end
    req = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int m_last = 1;  // channel 1 was the last grant before this test
    int ec, d, ecnt;
    logic [3:0] rv;
    for (int it = 0; it < 40; it++) begin
      if (it < 30) begin
        rv = 4'($urandom_range(1, 15));
        for (int c = 0; c < 4; c++) begin
          if (rv[c] && !req[c]) begin wd[c] = WIDTH'($urandom); req[c] = 1'b1; end
        end
      end
      if (req == 4'd0) break;
      ec = rr_next(m_last, req);
      ecnt = model_cnt(wd[ec]);
      d = $urandom_range(0, 3);
      res_ready = (d == 0);
      observe(1'b0, o_a, o_tack, o_xs, o_rnc, o_rns, o_xd, o_tval, o_ch, o_cnt, o_hit, o_ok);
      n_cmp++; if (!o_ok || o_a !== (4'b0001 << ec) || o_ch !== 2'(ec))
        begin n_err++; $display("FAIL rand_grant[%0d] ack=%b ch=%0d ok=%0d exp ch=%0d", it, o_a, o_ch, o_ok, ec); end
      n_cmp++; if (o_cnt !== CW'(ecnt) || o_hit !== (ecnt != 0) || o_xs !== wd[ec])
        begin n_err++; $display("FAIL rand_word[%0d] cnt=%0d hit=%b xs=%h exp %0d/%h", it, o_cnt, o_hit, o_xs, ecnt, wd[ec]); end
      n_cmp++; if (o_tval - o_tack !== WIDTH + 2 || o_rnc !== 1'b0 || o_rns !== 1'b1)
        begin n_err++; $display("FAIL rand_timing[%0d] lat=%0d clr=%b sh=%b", it, o_tval - o_tack, o_rnc, o_rns); end
      m_last = ec;
      for (int w = 0; w < d; w++) begin
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1 || res_ch !== o_ch || res_cnt !== o_cnt)
          begin n_err++; $display("FAIL rand_hold[%0d] valid=%b ch=%0d cnt=%0d", it, res_valid, res_ch, res_cnt); end
      end
      res_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (res_valid !== 1'b0)
        begin n_err++; $display("FAIL rand_accept[%0d] valid=%b exp=0", it, res_valid); end
    end
  endtask

  initial begin
    for (int c = 0; c < 4; c++) wd[c] = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_nomatch();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
